datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
- Multi-cycle instruction sequencer that drives the control inputs of the 16-bit register-file/ALU datapath.
- Latches one 16-bit instruction on a start handshake, decodes it, and steps a Moore FSM through register read, ALU, write-back and status-update cycles.
- Sits between the instruction source and the datapath. It is the initiating side of the datapath control interface.

Parameters:
- W, 16, datapath width; width of the sign-extended immediate driven on datapath_in.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- s  input  1  start request; sampled only in WAIT
- instr  input  16  instruction, latched when the start request is accepted
- w  output  1  idle/ready; 1 exactly when state==WAIT
- datapath_in  output  W  sign-extended instr[7:0] from the latched IR
- vsel  output  1  register-file write source: 0 = datapath_in, 1 = C register
- asel  output  1  1 forces ALU A operand to 0
- bsel  output  1  tied 0; shifted B register is the B operand
- loada, loadb, loadc, loads  output  1 each  pipeline/status register load enables
- write  output  1  register-file write enable
- writenum  output  3  register-file write address
- readnum  output  3  register-file read address
- ALUop  output  2  00 add, 01 subtract (CMP), 10 AND, 11 NOT B
- shift  output  2  shifter control, equal to IR[4:3]
- err  output  1  illegal-instruction flag; only present with ILLEGAL_TRAP_EN

Behaviour:
- IR fields:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0], imm8 = IR[7:0]
- Legal instructions:
  - 110/10 MOVI: Rn = sx(imm8)
  - 110/00 MOV: Rd = sh(Rm)
  - 101/00 ADD: Rd = Rn + sh(Rm)
  - 101/01 CMP: status = (Rn - sh(Rm) == 0); no register write
  - 101/10 AND: Rd = Rn & sh(Rm)
  - 101/11 MVN: Rd = ~sh(Rm)
  - Any other opcode/op combination is illegal.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_RD, WRITE_IMM, plus TRAP when ILLEGAL_TRAP_EN is defined.
- Accept: at the rising edge where state==WAIT and s==1, IR <= instr and state -> DECODE. s is ignored in every other state. If s is held high, the next instruction is accepted on the cycle after returning to WAIT.
- Transitions:
  - DECODE -> WRITE_IMM for MOVI; -> GET_B for MOV/MVN; -> GET_A for ADD/CMP/AND; illegal -> WAIT (or TRAP).
  - GET_A -> GET_B -> EXEC.
  - EXEC -> WAIT for CMP; otherwise EXEC -> WRITE_RD.
  - WRITE_RD -> WAIT, WRITE_IMM -> WAIT.
- Outputs are Moore, decoded combinationally from state and IR. Any output not listed for a state is 0.
  - WAIT: w=1.
  - WRITE_IMM: vsel=0, writenum=Rn, write=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC: shift=sh, ALUop=op, asel=1 for MOV/MVN (MOV uses ALUop=00), bsel=0, loadc=1 except for CMP; loads=1 only for CMP.
  - WRITE_RD: vsel=1, writenum=Rd, write=1.
- Cycles from the accept edge back to w=1:
  - MOVI 2; illegal (no trap) 1
  - MOV/MVN 4; ADD/AND 5; CMP 4
- datapath_in is always sx(IR[7:0]) to W bits: bit 7 replicated into bits W-1:8.
- Reset (asynchronous, any state, including mid-instruction):
  - state=WAIT, IR=0, err=0; w=1, all other control outputs 0.
  - An in-flight instruction is aborted with no register write and no status load.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to TRAP. In TRAP, err=1, w=0, all controls are 0 and s is ignored; only reset_n leaves TRAP.
- Undefined: an illegal instruction is a 1-cycle NOP (DECODE -> WAIT). There is no err port and no TRAP state.

Test Plan:
- Reset check: reset_n low mid-ADD (state EXEC) -> w=1 immediately, write=0, loadc=0; after release, state WAIT.
- MOVI: s=1, instr=16'hD1FE -> next cycle DECODE; following cycle write=1, writenum=1, vsel=0, datapath_in=16'hFFFE; w=1 on the third cycle.
- ADD: instr=16'hA148 (ADD R2,R1,R0 LSL#1) -> loada with readnum=1; then loadb with readnum=0; then loadc with shift=01, ALUop=00, asel=0; then write with writenum=2, vsel=1. w returns 5 cycles after accept.
- CMP: instr=16'hA800 -> in EXEC, loads=1, loadc=0, ALUop=01. No write pulse at any point; 4 cycles total.
- Handshake: s held at 1 with two back-to-back MOVIs (16'hD007, 16'hD1FE) -> second instruction accepted only on the WAIT edge. Toggling s and changing instr during busy cycles has no effect on IR.
- Illegal instr=16'hE000:
  - without ILLEGAL_TRAP_EN: back in WAIT 1 cycle after accept, no write.
  - with ILLEGAL_TRAP_EN: err=1, w=0 persists while s is pulsed; cleared only by reset_n.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer that drives the register-file/ALU datapath controls from one latched instruction.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions lock into TRAP (err=1) until reset instead of acting as a NOP.
module datapath_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s,
  input  logic [15:0]  instr,
  output logic         w,
  output logic [W-1:0] datapath_in,
  output logic         vsel,
  output logic         asel,
  output logic         bsel,
  output logic         loada,
  output logic         loadb,
  output logic         loadc,
  output logic         loads,
  output logic         write,
  output logic [2:0]   writenum,
  output logic [2:0]   readnum,
  output logic [1:0]   ALUop,
  output logic [1:0]   shift
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_RD, S_WRITE_IMM, S_TRAP
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;

  logic [2:0] w_opcode, w_rn, w_rd, w_rm;
  logic [1:0] w_op, w_sh;
  logic       w_is_movi, w_is_mov, w_is_alu, w_is_cmp, w_is_mvn;

  assign w_opcode  = r_ir[15:13];
  assign w_op      = r_ir[12:11];
  assign w_rn      = r_ir[10:8];
  assign w_rd      = r_ir[7:5];
  assign w_sh      = r_ir[4:3];
  assign w_rm      = r_ir[2:0];
  assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_mov  = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_alu  = (w_opcode == 3'b101);
  assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
  assign w_is_mvn  = w_is_alu && (w_op == 2'b11);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_WAIT: if (s) begin
          r_ir    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_is_movi)                  r_state <= S_WRITE_IMM;
          else if (w_is_mov || w_is_mvn)  r_state <= S_GET_B;
          else if (w_is_alu)              r_state <= S_GET_A;
`ifdef ILLEGAL_TRAP_EN
          else                            r_state <= S_TRAP;
`else
          else                            r_state <= S_WAIT;
`endif
        end
        S_GET_A:     r_state <= S_GET_B;
        S_GET_B:     r_state <= S_EXEC;
        S_EXEC:      r_state <= w_is_cmp ? S_WAIT : S_WRITE_RD;
        S_WRITE_RD:  r_state <= S_WAIT;
        S_WRITE_IMM: r_state <= S_WAIT;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:      r_state <= S_TRAP;
`endif
        default:     r_state <= S_WAIT;
      endcase
    end
  end

  // Immediate is presented continuously; only vsel/write decide when it matters.
  assign datapath_in = {{(W-8){r_ir[7]}}, r_ir[7:0]};
  assign bsel        = 1'b0;

`ifdef ILLEGAL_TRAP_EN
  assign err = (r_state == S_TRAP);
`endif

  always_comb begin
    w        = 1'b0;
    vsel     = 1'b0;
    asel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    ALUop    = 2'b00;
    shift    = 2'b00;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        writenum = w_rn;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = w_sh;
        ALUop = w_is_mov ? 2'b00 : w_op;
        asel  = w_is_mov || w_is_mvn;
        loadc = !w_is_cmp;
        loads = w_is_cmp;
      end
      S_WRITE_RD: begin
        vsel     = 1'b1;
        writenum = w_rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed-vector bench for datapath_ctrl: walks each instruction class cycle by cycle against hand-built control words.
module tb_datapath_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s;
  logic [15:0]  instr;
  logic         w, vsel, asel, bsel, loada, loadb, loadc, loads, write;
  logic [W-1:0] datapath_in;
  logic [2:0]   writenum, readnum;
  logic [1:0]   ALUop, shift;
`ifdef ILLEGAL_TRAP_EN
  logic         err;
`endif

  int cmp_cnt = 0;
  int mis_cnt = 0;

  datapath_ctrl #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .instr(instr), .w(w),
    .datapath_in(datapath_in), .vsel(vsel), .asel(asel), .bsel(bsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .write(write), .writenum(writenum), .readnum(readnum),
    .ALUop(ALUop), .shift(shift)
`ifdef ILLEGAL_TRAP_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Control word: {w,vsel,asel,bsel,loada,loadb,loadc,loads,write,writenum,readnum,ALUop,shift}
  logic [18:0] ctl;
  assign ctl = {w, vsel, asel, bsel, loada, loadb, loadc, loads, write,
                writenum, readnum, ALUop, shift};

  function automatic logic [18:0] c(input logic w_, vs, as, bs, la, lb, lc, ls, wr,
                                    input logic [2:0] wn, rn,
                                    input logic [1:0] aop, sh);
    return {w_, vs, as, bs, la, lb, lc, ls, wr, wn, rn, aop, sh};
  endfunction

  localparam logic [18:0] IDLE = 19'b1_0000_0000_000_000_00_00;
  localparam logic [18:0] NONE = 19'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with s=1 for exactly the accept edge; state is DECODE on return.
  task automatic start(input logic [15:0] ins);
    s = 1'b1;
    instr = ins;
    tick();
    s = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s = 1'b0; instr = 16'h0000;
    tick(); tick();
    cmp_cnt++;
    if (ctl !== IDLE) begin mis_cnt++; $display("FAIL reset_ctl: got %h expected %h", ctl, IDLE); end
    cmp_cnt++;
    if (datapath_in !== 16'h0000) begin mis_cnt++; $display("FAIL reset_dpin: got %h expected 0000", datapath_in); end
    #2 reset_n = 1'b1;
    tick();
    cmp_cnt++;
    if (ctl !== IDLE) begin mis_cnt++; $display("FAIL reset_release: got %h expected %h", ctl, IDLE); end
  endtask

  task automatic test_movi();
    logic [18:0] ex [0:2];
    ex = '{NONE, c(0,0,0,0,0,0,0,0,1,3'd1,3'd0,2'b00,2'b00), IDLE};
    start(16'hD1FE);
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++;
      if (ctl !== ex[i]) begin mis_cnt++; $display("FAIL movi_c%0d: got %h expected %h", i, ctl, ex[i]); end
      if (i == 1) begin
        cmp_cnt++;
        if (datapath_in !== 16'hFFFE) begin mis_cnt++; $display("FAIL movi_dpin: got %h expected fffe", datapath_in); end
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_add();
    logic [18:0] ex [0:5];
    ex = '{NONE,
           c(0,0,0,0,1,0,0,0,0,3'd0,3'd1,2'b00,2'b00),
           c(0,0,0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b00),
           c(0,0,0,0,0,0,1,0,0,3'd0,3'd0,2'b00,2'b01),
           c(0,1,0,0,0,0,0,0,1,3'd2,3'd0,2'b00,2'b00),
           IDLE};
    start(16'hA148);
    for (int i = 0; i < 6; i++) begin
      // Busy-cycle noise on s/instr must not disturb the latched instruction.
      s = i[0]; instr = 16'hFFFF;
      cmp_cnt++;
      if (ctl !== ex[i]) begin mis_cnt++; $display("FAIL add_c%0d: got %h expected %h", i, ctl, ex[i]); end
      if (i < 5) tick();
    end
    s = 1'b0;
    cmp_cnt++;
    if (datapath_in !== 16'h0048) begin mis_cnt++; $display("FAIL add_ir_hold: got %h expected 0048", datapath_in); end
  endtask

  task automatic test_cmp();
    logic [18:0] ex [0:4];
    ex = '{NONE,
           c(0,0,0,0,1,0,0,0,0,3'd0,3'd0,2'b00,2'b00),
           c(0,0,0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b00),
           c(0,0,0,0,0,0,0,1,0,3'd0,3'd0,2'b01,2'b00),
           IDLE};
    start(16'hA800);
    for (int i = 0; i < 5; i++) begin
      cmp_cnt++;
      if (ctl !== ex[i]) begin mis_cnt++; $display("FAIL cmp_c%0d: got %h expected %h", i, ctl, ex[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_mov_mvn_and();
    logic [15:0] ins [0:2];
    logic [15:0] dp  [0:2];
    logic [18:0] ex  [0:2][0:5];
    int          len [0:2];
    ins = '{16'hC076, 16'hB8E5, 16'hB399};
    dp  = '{16'h0076, 16'hFFE5, 16'hFF99};
    len = '{5, 5, 6};
    ex[0] = '{NONE, c(0,0,0,0,0,1,0,0,0,3'd0,3'd6,2'b00,2'b00),
              c(0,0,1,0,0,0,1,0,0,3'd0,3'd0,2'b00,2'b10),
              c(0,1,0,0,0,0,0,0,1,3'd3,3'd0,2'b00,2'b00), IDLE, IDLE};
    ex[1] = '{NONE, c(0,0,0,0,0,1,0,0,0,3'd0,3'd5,2'b00,2'b00),
              c(0,0,1,0,0,0,1,0,0,3'd0,3'd0,2'b11,2'b00),
              c(0,1,0,0,0,0,0,0,1,3'd7,3'd0,2'b00,2'b00), IDLE, IDLE};
    ex[2] = '{NONE, c(0,0,0,0,1,0,0,0,0,3'd0,3'd3,2'b00,2'b00),
              c(0,0,0,0,0,1,0,0,0,3'd0,3'd1,2'b00,2'b00),
              c(0,0,0,0,0,0,1,0,0,3'd0,3'd0,2'b10,2'b11),
              c(0,1,0,0,0,0,0,0,1,3'd4,3'd0,2'b00,2'b00), IDLE};
    for (int k = 0; k < 3; k++) begin
      start(ins[k]);
      cmp_cnt++;
      if (datapath_in !== dp[k]) begin mis_cnt++; $display("FAIL op%0d_dpin: got %h expected %h", k, datapath_in, dp[k]); end
      for (int i = 0; i < len[k]; i++) begin
        cmp_cnt++;
        if (ctl !== ex[k][i]) begin mis_cnt++; $display("FAIL op%0d_c%0d: got %h expected %h", k, i, ctl, ex[k][i]); end
        if (i < len[k] - 1) tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    s = 1'b1; instr = 16'hD007;
    tick();                      // accept D007 -> DECODE
    instr = 16'hD1FE;
    tick();                      // WRITE_IMM for D007
    cmp_cnt++;
    if (ctl !== c(0,0,0,0,0,0,0,0,1,3'd0,3'd0,2'b00,2'b00) || datapath_in !== 16'h0007) begin
      mis_cnt++; $display("FAIL b2b_first: got %h/%h expected write R0 with 0007", ctl, datapath_in);
    end
    tick();
    cmp_cnt++;
    if (ctl !== IDLE || datapath_in !== 16'h0007) begin
      mis_cnt++; $display("FAIL b2b_wait: got %h/%h expected %h/0007", ctl, datapath_in, IDLE);
    end
    tick();                      // s still high: second MOVI accepted here
    cmp_cnt++;
    if (ctl !== NONE || datapath_in !== 16'hFFFE) begin
      mis_cnt++; $display("FAIL b2b_accept2: got %h/%h expected %h/fffe", ctl, datapath_in, NONE);
    end
    s = 1'b0;
    tick();
    cmp_cnt++;
    if (ctl !== c(0,0,0,0,0,0,0,0,1,3'd1,3'd0,2'b00,2'b00)) begin
      mis_cnt++; $display("FAIL b2b_second: got %h expected write R1", ctl);
    end
    tick();
    cmp_cnt++;
    if (ctl !== IDLE) begin mis_cnt++; $display("FAIL b2b_end: got %h expected %h", ctl, IDLE); end
  endtask

  task automatic test_reset_mid_add();
    start(16'hA148);
    tick(); tick(); tick();      // GET_A, GET_B, EXEC
    cmp_cnt++;
    if (loadc !== 1'b1) begin mis_cnt++; $display("FAIL midrst_exec: got loadc=%b expected 1", loadc); end
    #2 reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if (ctl !== IDLE || datapath_in !== 16'h0000) begin
      mis_cnt++; $display("FAIL midrst_async: got %h/%h expected %h/0000", ctl, datapath_in, IDLE);
    end
    #2 reset_n = 1'b1;
    tick();
    cmp_cnt++;
    if (ctl !== IDLE) begin mis_cnt++; $display("FAIL midrst_after: got %h expected %h", ctl, IDLE); end
  endtask

  task automatic test_illegal();
    logic [15:0] bad [0:2];
    bad = '{16'hE000, 16'hC800, 16'h8000};
`ifdef ILLEGAL_TRAP_EN
    start(bad[0]);
    tick();
    for (int i = 0; i < 4; i++) begin
      s = i[0];
      cmp_cnt++;
      if (err !== 1'b1 || ctl !== NONE) begin
        mis_cnt++; $display("FAIL trap_c%0d: got err=%b ctl=%h expected err=1 ctl=%h", i, err, ctl, NONE);
      end
      tick();
    end
    s = 1'b0;
    reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if (err !== 1'b0 || ctl !== IDLE) begin
      mis_cnt++; $display("FAIL trap_reset: got err=%b ctl=%h expected err=0 ctl=%h", err, ctl, IDLE);
    end
    #2 reset_n = 1'b1;
    tick();
`else
    for (int k = 0; k < 3; k++) begin
      start(bad[k]);
      cmp_cnt++;
      if (ctl !== NONE) begin mis_cnt++; $display("FAIL ill%0d_decode: got %h expected %h", k, ctl, NONE); end
      tick();
      cmp_cnt++;
      if (ctl !== IDLE) begin mis_cnt++; $display("FAIL ill%0d_wait: got %h expected %h", k, ctl, IDLE); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_movi();
    test_add();
    test_cmp();
    test_mov_mvn_and();
    test_back_to_back();
    test_reset_mid_add();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
